// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions.
// Handshake state encoding and default widths.
package arith_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_t;

  localparam int MUL_W  = 8;
  localparam int DIV_DW = 16;
  localparam int DIV_VW = 8;

endpackage

// File: rtl/div_step.sv
// One restoring-division step.
// Shifts in a dividend bit, trial-subtracts the divisor.
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW-1:0] rem,
  input  logic          din,
  input  logic [VW-1:0] b,
  output logic [VW-1:0] rem_n,
  output logic          qbit
);

  logic [VW:0] sh;
  logic [VW:0] bx;

  assign sh = {rem, din};
  assign bx = {1'b0, b};

  // Trial subtract; the partial remainder stays below b, so VW bits hold it
  always_comb begin
    qbit  = (sh >= bx);
    rem_n = sh[VW-1:0];
    if (qbit) begin
      rem_n = VW'(sh - bx);
    end
  end

endmodule

// File: rtl/div.sv
// Sequential restoring divider, one quotient bit per clock.
// start/busy handshake shared with the shift-add multiplier.
module div
  import arith_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] a_bi,
  input  logic [VW-1:0] b_bi,
  input  logic          start_i,
  output logic          busy_o,
  output logic [DW-1:0] q_bo,
  output logic [VW-1:0] r_bo,
  output logic          dz_o
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_t        state;
  state_t        state_n;
  logic [DW-1:0] a_q;
  logic [VW-1:0] b_q;
  logic [VW-1:0] rem;
  logic [VW-1:0] rem_n;
  logic [DW-1:0] qw;
  logic          qbit;
  logic [CW-1:0] ctr;
  logic          last;

  assign last   = (ctr == LAST);
  assign busy_o = (state == WORK);

  div_step #(
    .VW(VW)
  ) u_step (
    .rem  (rem),
    .din  (a_q[DW-1]),
    .b    (b_q),
    .rem_n(rem_n),
    .qbit (qbit)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: accept in IDLE, finish after DW steps
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start_i) state_n = WORK;
      WORK: if (last)    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_q  <= '0;
      b_q  <= '0;
      rem  <= '0;
      qw   <= '0;
      ctr  <= '0;
      q_bo <= '0;
      r_bo <= '0;
      dz_o <= 1'b0;
    end else if (state == IDLE) begin
      if (start_i) begin
        a_q <= a_bi;
        b_q <= b_bi;
        rem <= '0;
        qw  <= '0;
        ctr <= '0;
      end
    end else begin
      a_q <= {a_q[DW-2:0], 1'b0};
      rem <= rem_n;
      qw  <= {qw[DW-2:0], qbit};
      ctr <= ctr + CW'(1);
      if (last) begin
        q_bo <= {qw[DW-2:0], qbit};
        r_bo <= rem_n;
        dz_o <= (b_q == '0);
      end
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed and random checks for the divider.
// Immediate assertions count and report every mismatch.
module tb_div;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  b;
  logic        start;
  logic        busy;
  logic [15:0] q;
  logic [7:0]  r;
  logic        dz;

  int total = 0;
  int fails = 0;
  int cyc;
  int ra;
  int rb;

  div #(
    .DW(16),
    .VW(8)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .a_bi   (a),
    .b_bi   (b),
    .start_i(start),
    .busy_o (busy),
    .q_bo   (q),
    .r_bo   (r),
    .dz_o   (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // count negedges with busy high after the accepting edge
  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run(input logic [15:0] ai, input logic [7:0] bi,
                     output int n);
    @(negedge clk);
    a = ai;
    b = bi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
  endtask

  initial begin
    rst = 1'b0;
    a = '0;
    b = '0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_r", 32'(r), 0);
    chk("rst_dz", 32'(dz), 0);
    rst = 1'b1;

    run(16'd100, 8'd7, cyc);
    chk("100/7 cyc", cyc, 16);
    chk("100/7 q", 32'(q), 14);
    chk("100/7 r", 32'(r), 2);
    chk("100/7 dz", 32'(dz), 0);

    run(16'd65535, 8'd255, cyc);
    chk("65535/255 q", 32'(q), 257);
    chk("65535/255 r", 32'(r), 0);

    run(16'd3, 8'd200, cyc);
    chk("3/200 q", 32'(q), 0);
    chk("3/200 r", 32'(r), 3);

    run(16'h1234, 8'd0, cyc);
    chk("dz cyc", cyc, 16);
    chk("dz q", 32'(q), 32'hFFFF);
    chk("dz r", 32'(r), 32'h34);
    chk("dz dz", 32'(dz), 1);

    run(16'd10, 8'd3, cyc);
    chk("10/3 q", 32'(q), 3);
    chk("10/3 r", 32'(r), 1);
    chk("10/3 dz", 32'(dz), 0);

    // start pulse in flight must be ignored
    @(negedge clk);
    a = 16'd1000;
    b = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (cyc == 5) begin
        a = 16'd7;
        b = 8'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign cyc", cyc, 16);
    chk("ign q", 32'(q), 111);
    chk("ign r", 32'(r), 1);

    // asynchronous reset mid-operation
    @(negedge clk);
    a = 16'd1000;
    b = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst busy", 32'(busy), 0);
    chk("arst q", 32'(q), 0);
    chk("arst r", 32'(r), 0);
    chk("arst dz", 32'(dz), 0);
    @(negedge clk);
    rst = 1'b1;

    run(16'd50, 8'd5, cyc);
    chk("50/5 cyc", cyc, 16);
    chk("50/5 q", 32'(q), 10);
    chk("50/5 r", 32'(r), 0);

    // back-to-back random operations with start held high
    @(negedge clk);
    ra = int'($urandom_range(0, 65535));
    rb = int'($urandom_range(1, 255));
    a = 16'(ra);
    b = 8'(rb);
    start = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      wait_done(cyc);
      chk("rnd cyc", cyc, 16);
      chk("rnd q", 32'(q), 32'(ra / rb));
      chk("rnd r", 32'(r), 32'(ra % rb));
      if (k < 999) begin
        ra = int'($urandom_range(0, 65535));
        rb = int'($urandom_range(1, 255));
        a = 16'(ra);
        b = 8'(rb);
      end else begin
        start = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
